// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared types, character constants and baud divider helper     |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam logic [7:0] NUL = 8'h00;
    localparam logic [7:0] CR  = 8'h0D;

    // BREAK holds off start detection until a low stop bit has cleared
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } byte_state_t;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        READY = 1'b1
    } line_state_t;

    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_byte : rx synchroniser, bit timer and 8N1/8E1 byte deframer      |
// | Option macro : UART_RX_PARITY_EN (even parity bit after data bit 7)      |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 24_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int              c_div  = uart_div(CLK_HZ, BAUD);
    localparam int              c_tw   = $clog2(c_div) + 1;
    localparam logic [c_tw-1:0] c_half = c_tw'(c_div / 2);
    localparam logic [c_tw-1:0] c_full = c_tw'(c_div);
    localparam logic [c_tw-1:0] c_one  = c_tw'(1);

    byte_state_t     r_state;
    byte_state_t     w_state_next;
    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    logic [c_tw-1:0] r_timer;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_byte_valid;
    logic            r_frame_err;
    logic            w_expire;
    logic            w_load_half;
    logic            w_load_full;
    logic            w_shift;
    logic            w_valid;
    logic            w_err;
    logic            w_par_ok;

`ifdef UART_RX_PARITY_EN
    localparam byte_state_t c_after_data = PARITY;
    logic r_par_bit;
    logic w_par_sample;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_par_bit <= 1'b0;
        else if (w_par_sample)
            r_par_bit <= r_rx_sync;
    end

    assign w_par_ok = ~((^r_shift) ^ r_par_bit);
`else
    localparam byte_state_t c_after_data = STOP;
    assign w_par_ok = 1'b1;
`endif

    assign w_expire = (r_timer == c_one);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_shift      = 1'b0;
        w_valid      = 1'b0;
        w_err        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            IDLE: if (r_rx_prev && !r_rx_sync) begin
                w_state_next = START;
                w_load_half  = 1'b1;
            end
            START: if (w_expire) begin
                if (!r_rx_sync) begin
                    w_state_next = DATA;
                    w_load_full  = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DATA: if (w_expire) begin
                w_shift     = 1'b1;
                w_load_full = 1'b1;
                if (r_bit_cnt == 3'd7)
                    w_state_next = c_after_data;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_expire) begin
                w_par_sample = 1'b1;
                w_load_full  = 1'b1;
                w_state_next = STOP;
            end
`endif
            STOP: if (w_expire) begin
                if (r_rx_sync && w_par_ok) begin
                    w_valid      = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_err        = 1'b1;
                    w_state_next = r_rx_sync ? IDLE : BREAK;
                end
            end
            BREAK: if (r_rx_sync)
                w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Synchroniser resets to idle-high so leaving reset never fakes a start edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_timer      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (w_load_half)
                r_timer <= c_half;
            else if (w_load_full)
                r_timer <= c_full;
            else if (r_timer != '0)
                r_timer <= r_timer - c_one;
            if (w_load_half)
                r_bit_cnt <= '0;
            else if (w_shift)
                r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_shift)
                r_shift <= {r_rx_sync, r_shift[7:1]};
            r_byte_valid <= w_valid;
            r_frame_err  <= w_err;
        end
    end

    assign data_o       = r_shift;
    assign byte_valid_o = r_byte_valid;
    assign frame_err_o  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/uart_line_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_line_rx : UART receiver collecting a null-terminated line in RAM    |
// | Option macro : UART_RX_PARITY_EN (8E1 frames, handled in uart_rx_byte)   |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module uart_line_rx
    import uart_pkg::*;
#(
    parameter int         CLK_HZ = 24_000_000,
    parameter int         BAUD   = 115200,
    parameter int         ADDR_W = 4,
    parameter logic [7:0] TERM   = CR
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic              line_ready_o,
    output logic [ADDR_W:0]   line_len_o,
    input  logic              ack_i,
    output logic              overflow_o,
    output logic              frame_err_o
);

    localparam int                c_depth   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ptr_max = '1;

    line_state_t       r_state;
    line_state_t       w_state_next;
    logic [7:0]        r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_line_len;
    logic              r_overflow;
    logic [7:0]        r_rd_data;
    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic              w_ptr_inc;
    logic              w_set_ovf;
    logic              w_done;
    logic              w_release;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx_byte (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .data_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .frame_err_o  (frame_err_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= FILL;
        else
            r_state <= w_state_next;
    end

    // The last slot is reserved for the null, so payload saturates at DEPTH-1
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_wdata      = w_byte;
        w_ptr_inc    = 1'b0;
        w_set_ovf    = 1'b0;
        w_done       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            FILL: if (w_byte_valid) begin
                if (w_byte == TERM || w_byte == NUL) begin
                    w_we         = 1'b1;
                    w_wdata      = NUL;
                    w_done       = 1'b1;
                    w_state_next = READY;
                end else if (r_wr_ptr != c_ptr_max) begin
                    w_we      = 1'b1;
                    w_ptr_inc = 1'b1;
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            READY: begin
                w_set_ovf = w_byte_valid;
                if (ack_i) begin
                    w_release    = 1'b1;
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // A drop coinciding with the ack wins, keeping overflow visible
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_line_len <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_release)
                r_wr_ptr <= '0;
            else if (w_ptr_inc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_done)
                r_line_len <= {1'b0, r_wr_ptr};
            if (w_set_ovf)
                r_overflow <= 1'b1;
            else if (w_release)
                r_overflow <= 1'b0;
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we)
            r_mem[r_wr_ptr] <= w_wdata;
    end

    assign rd_data_o    = r_rd_data;
    assign line_ready_o = (r_state == READY);
    assign line_len_o   = r_line_len;
    assign overflow_o   = r_overflow;

endmodule
`default_nettype wire
